// File: rtl/zcu104_main_pkg.sv
// Shared constants, register selectors and AXI FSM state types for the ZCU104 main block.
package zcu104_main_pkg;

   localparam logic [38:0] DEF_CTRL_ADDR = 39'h00_A000_0000;
   localparam logic [38:0] DEF_IMG_BASE  = 39'h00_A001_0000;

   localparam logic [38:0] OFF_FRAME = 39'h00;
   localparam logic [38:0] OFF_GEOM  = 39'h20;
   localparam logic [38:0] OFF_PIX   = 39'h30;
   localparam logic [38:0] OFF_ACK   = 39'h40;

   localparam int unsigned CTRL_START    = 0;
   localparam int unsigned CTRL_SOFT_RST = 1;
   localparam int unsigned CTRL_AUTO     = 3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {WI_IDLE, WI_DATA, WI_RESP} wr_state_t;
   typedef enum logic       {RI_IDLE, RI_DATA} rd_state_t;
   typedef enum logic [2:0] {REG_NONE, REG_CTRL, REG_FRAME, REG_GEOM, REG_PIX, REG_ACK} reg_sel_t;

   function automatic reg_sel_t decode_addr(input logic [38:0] addr,
                                            input logic [38:0] ctrl_addr,
                                            input logic [38:0] img_base);
      if (addr == ctrl_addr)            return REG_CTRL;
      if (addr == img_base + OFF_FRAME) return REG_FRAME;
      if (addr == img_base + OFF_GEOM)  return REG_GEOM;
      if (addr == img_base + OFF_PIX)   return REG_PIX;
      if (addr == img_base + OFF_ACK)   return REG_ACK;
      return REG_NONE;
   endfunction

   function automatic logic [127:0] apply_strb(input logic [127:0] old_word,
                                               input logic [127:0] new_word,
                                               input logic [15:0]  strb);
      logic [127:0] res;
      res = old_word;
      for (int unsigned i = 0; i < 16; i++) begin
         if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/zcu104_pix_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
module zcu104_pix_fifo #(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned WIDTH = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   typedef logic [AW:0] cnt_t;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   cnt_t             count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == cnt_t'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem[rd_ptr_q];

   always_comb begin
      do_push  = push && !full && !flush;
      do_pop   = pop && !empty && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + cnt_t'(do_push) - cnt_t'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/zcu104_main_blk_wrapper.sv
// AXI4 slave holding the master control register and the image controller that
// feeds host-written pixel bursts through a FIFO onto a pixel stream.
module zcu104_main_blk_wrapper
   import zcu104_main_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 512,
   parameter int unsigned BURST_MAX  = 256,
   parameter logic [38:0] CTRL_ADDR  = DEF_CTRL_ADDR,
   parameter logic [38:0] IMG_BASE   = DEF_IMG_BASE
) (
   input  logic          s_axi_aclk,
   input  logic          s_axi_areset,
   input  logic [38:0]   S00_AXI_0_awaddr,
   input  logic [7:0]    S00_AXI_0_awlen,
   input  logic          S00_AXI_0_awvalid,
   output logic          S00_AXI_0_awready,
   input  logic [1:0]    S00_AXI_0_awburst,
   input  logic [2:0]    S00_AXI_0_awsize,
   input  logic [3:0]    S00_AXI_0_awcache,
   input  logic          S00_AXI_0_awlock,
   input  logic [2:0]    S00_AXI_0_awprot,
   input  logic [3:0]    S00_AXI_0_awqos,
   input  logic [127:0]  S00_AXI_0_wdata,
   input  logic [15:0]   S00_AXI_0_wstrb,
   input  logic          S00_AXI_0_wlast,
   input  logic          S00_AXI_0_wvalid,
   output logic          S00_AXI_0_wready,
   output logic [1:0]    S00_AXI_0_bresp,
   output logic          S00_AXI_0_bvalid,
   input  logic          S00_AXI_0_bready,
   input  logic [38:0]   S00_AXI_0_araddr,
   input  logic [7:0]    S00_AXI_0_arlen,
   input  logic          S00_AXI_0_arvalid,
   output logic          S00_AXI_0_arready,
   input  logic [1:0]    S00_AXI_0_arburst,
   input  logic [2:0]    S00_AXI_0_arsize,
   input  logic [3:0]    S00_AXI_0_arcache,
   input  logic          S00_AXI_0_arlock,
   input  logic [2:0]    S00_AXI_0_arprot,
   input  logic [3:0]    S00_AXI_0_arqos,
   output logic [127:0]  S00_AXI_0_rdata,
   output logic [1:0]    S00_AXI_0_rresp,
   output logic          S00_AXI_0_rlast,
   output logic          S00_AXI_0_rvalid,
   input  logic          S00_AXI_0_rready,
   input  logic          image_change,
   output logic          irq_signal,
   output logic [127:0]  m_pix_tdata,
   output logic          m_pix_tvalid,
   input  logic          m_pix_tready
);
   wr_state_t wr_state_q, wr_state_d;
   rd_state_t rd_state_q, rd_state_d;
   reg_sel_t  wsel_q, wsel_d, rsel_q, rsel_d;
   logic      awready_q, awready_d, arready_q, arready_d, wfirst_q, wfirst_d;
   logic [7:0]  rbeats_q, rbeats_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [63:0] base_q, base_d, geom_q, geom_d;
   logic [31:0] pcount_q, pcount_d, requested_q, requested_d, popped_q, popped_d;
   logic [8:0]  grant_q, grant_d;
   logic        irq_q, irq_d;

   logic [127:0] wr_old, wmerged, rd_word;
   logic [31:0]  frame_beats, remaining, want, free_slots;
   logic         wbeat, reg_wr, ack, req_ok, running, flush, pix_push, pix_pop;
   logic         fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic         unused_inputs;

   assign unused_inputs = ^{S00_AXI_0_awlen, S00_AXI_0_awburst, S00_AXI_0_awsize,
                            S00_AXI_0_awcache, S00_AXI_0_awlock, S00_AXI_0_awprot,
                            S00_AXI_0_awqos, S00_AXI_0_arburst, S00_AXI_0_arsize,
                            S00_AXI_0_arcache, S00_AXI_0_arlock, S00_AXI_0_arprot,
                            S00_AXI_0_arqos, wmerged[127:96]};

   zcu104_pix_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(128)) u_fifo (
      .clk   (s_axi_aclk),
      .rst   (s_axi_areset),
      .flush (flush),
      .push  (pix_push),
      .pop   (pix_pop),
      .din   (S00_AXI_0_wdata),
      .dout  (m_pix_tdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign S00_AXI_0_awready = awready_q;
   assign S00_AXI_0_arready = arready_q;
   assign S00_AXI_0_wready  = (wr_state_q == WI_DATA) && ((wsel_q != REG_PIX) || !fifo_full);
   assign S00_AXI_0_bvalid  = (wr_state_q == WI_RESP);
   assign S00_AXI_0_bresp   = (S00_AXI_0_bvalid && wsel_q == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
   assign S00_AXI_0_rvalid  = (rd_state_q == RI_DATA);
   assign S00_AXI_0_rlast   = S00_AXI_0_rvalid && (rbeats_q == '0);
   assign S00_AXI_0_rresp   = (S00_AXI_0_rvalid && rsel_q == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
   assign S00_AXI_0_rdata   = S00_AXI_0_rvalid ? rd_word : '0;
   assign irq_signal        = irq_q;

   assign running      = ctrl_q[CTRL_START] && !ctrl_q[CTRL_SOFT_RST];
   assign m_pix_tvalid = running && !fifo_empty;
   assign pix_pop      = m_pix_tvalid && m_pix_tready;
   assign flush        = ctrl_q[CTRL_SOFT_RST] || image_change;
   assign wbeat        = S00_AXI_0_wvalid && S00_AXI_0_wready;
   assign reg_wr       = wbeat && wfirst_q;
   assign pix_push     = wbeat && (wsel_q == REG_PIX);
   assign ack          = reg_wr && (wsel_q == REG_ACK) && S00_AXI_0_wdata[0] && S00_AXI_0_wstrb[0];

   // Request sizing: beats still owed this frame, capped at BURST_MAX, must fit the FIFO.
   assign frame_beats = {2'b00, pcount_q[31:2]} + {31'd0, |pcount_q[1:0]};
   assign remaining   = frame_beats - requested_q;
   assign want        = (remaining > 32'(BURST_MAX)) ? 32'(BURST_MAX) : remaining;
   assign free_slots  = 32'(FIFO_DEPTH) - 32'(fifo_count);
   assign req_ok      = running && !irq_q && (requested_q < frame_beats) && (free_slots >= want);

   always_comb begin
      rd_word = '0;
      wr_old  = '0;
      unique case (rsel_q)
         REG_CTRL:  rd_word = {124'd0, ctrl_q};
         REG_FRAME: rd_word = {55'd0, grant_q, base_q};
         REG_GEOM:  rd_word = {64'd0, geom_q};
         default:   rd_word = '0;
      endcase
      unique case (wsel_q)
         REG_CTRL:  wr_old = {124'd0, ctrl_q};
         REG_FRAME: wr_old = {32'd0, pcount_q, base_q};
         REG_GEOM:  wr_old = {64'd0, geom_q};
         default:   wr_old = '0;
      endcase
      wmerged = apply_strb(wr_old, S00_AXI_0_wdata, S00_AXI_0_wstrb);
   end

   always_comb begin
      wr_state_d = wr_state_q;
      awready_d  = 1'b0;
      wsel_d     = wsel_q;
      wfirst_d   = wfirst_q;
      unique case (wr_state_q)
         WI_IDLE: if (S00_AXI_0_awvalid) begin
            if (awready_q) begin
               wsel_d     = decode_addr(S00_AXI_0_awaddr, CTRL_ADDR, IMG_BASE);
               wfirst_d   = 1'b1;
               wr_state_d = WI_DATA;
            end else begin
               awready_d = 1'b1;
            end
         end
         WI_DATA: if (wbeat) begin
            wfirst_d = 1'b0;
            if (S00_AXI_0_wlast) wr_state_d = WI_RESP;
         end
         WI_RESP: if (S00_AXI_0_bready) wr_state_d = WI_IDLE;
         default: wr_state_d = WI_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      arready_d  = 1'b0;
      rsel_d     = rsel_q;
      rbeats_d   = rbeats_q;
      unique case (rd_state_q)
         RI_IDLE: if (S00_AXI_0_arvalid) begin
            if (arready_q) begin
               rsel_d     = decode_addr(S00_AXI_0_araddr, CTRL_ADDR, IMG_BASE);
               rbeats_d   = S00_AXI_0_arlen;
               rd_state_d = RI_DATA;
            end else begin
               arready_d = 1'b1;
            end
         end
         RI_DATA: if (S00_AXI_0_rready) begin
            if (rbeats_q == '0) rd_state_d = RI_IDLE;
            else                rbeats_d   = rbeats_q - 8'd1;
         end
         default: rd_state_d = RI_IDLE;
      endcase
   end

   always_comb begin
      ctrl_d      = ctrl_q;
      base_d      = base_q;
      pcount_d    = pcount_q;
      geom_d      = geom_q;
      grant_d     = grant_q;
      irq_d       = irq_q;
      requested_d = requested_q;
      popped_d    = popped_q;
      if (pix_pop) begin
         if (popped_q + 32'd1 == frame_beats) begin
            requested_d = '0;
            popped_d    = '0;
            if (!ctrl_q[CTRL_AUTO]) ctrl_d[CTRL_START] = 1'b0;
         end else begin
            popped_d = popped_q + 32'd1;
         end
      end
      if (reg_wr) begin
         unique case (wsel_q)
            REG_CTRL:  ctrl_d = wmerged[3:0];
            REG_FRAME: begin
               base_d   = wmerged[63:0];
               pcount_d = wmerged[95:64];
            end
            REG_GEOM:  geom_d = wmerged[63:0];
            default:   ;
         endcase
      end
      // Event precedence: flush sources > acknowledge > new burst request.
      if (flush) begin
         irq_d       = 1'b0;
         grant_d     = '0;
         requested_d = '0;
         popped_d    = '0;
      end else if (ack) begin
         irq_d   = 1'b0;
         grant_d = '0;
      end else if (req_ok) begin
         irq_d       = 1'b1;
         grant_d     = want[8:0];
         requested_d = requested_q + want;
      end
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         wr_state_q  <= WI_IDLE;
         rd_state_q  <= RI_IDLE;
         wsel_q      <= REG_NONE;
         rsel_q      <= REG_NONE;
         awready_q   <= 1'b0;
         arready_q   <= 1'b0;
         wfirst_q    <= 1'b0;
         rbeats_q    <= '0;
         ctrl_q      <= '0;
         base_q      <= '0;
         pcount_q    <= '0;
         geom_q      <= '0;
         grant_q     <= '0;
         irq_q       <= 1'b0;
         requested_q <= '0;
         popped_q    <= '0;
      end else begin
         wr_state_q  <= wr_state_d;
         rd_state_q  <= rd_state_d;
         wsel_q      <= wsel_d;
         rsel_q      <= rsel_d;
         awready_q   <= awready_d;
         arready_q   <= arready_d;
         wfirst_q    <= wfirst_d;
         rbeats_q    <= rbeats_d;
         ctrl_q      <= ctrl_d;
         base_q      <= base_d;
         pcount_q    <= pcount_d;
         geom_q      <= geom_d;
         grant_q     <= grant_d;
         irq_q       <= irq_d;
         requested_q <= requested_d;
         popped_q    <= popped_d;
      end
   end

endmodule

// File: tb/tb_zcu104_main_blk_wrapper.sv
// Directed bench for the ZCU104 main block: AXI register access, IRQ burst flow and pixel stream.
module tb_zcu104_main_blk_wrapper;
   localparam logic [38:0] A_CTRL  = 39'h00_A000_0000;
   localparam logic [38:0] A_FRAME = 39'h00_A001_0000;
   localparam logic [38:0] A_GEOM  = 39'h00_A001_0020;
   localparam logic [38:0] A_PIX   = 39'h00_A001_0030;
   localparam logic [38:0] A_ACK   = 39'h00_A001_0040;
   localparam logic [38:0] A_BAD   = 39'h00_A002_0000;
   localparam logic [63:0] DRAM_BASE = 64'h4_0000_0000;

   logic clk = 1'b0;
   logic rst;
   logic [38:0] awaddr, araddr;
   logic [7:0] awlen, arlen;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rlast, rvalid, rready;
   logic [127:0] wdata, rdata, tdata;
   logic [15:0] wstrb;
   logic [1:0] bresp, rresp;
   logic image_change, irq_signal, tvalid, tready;

   int errors = 0;
   int checks = 0;
   logic [1:0]   bq[$];
   logic [127:0] rdq[$];
   logic [1:0]   rrq[$];
   logic [127:0] pq[$];
   logic         irq_at_last_beat;

   always #5 clk = ~clk;

   zcu104_main_blk_wrapper dut (
      .s_axi_aclk(clk), .s_axi_areset(rst),
      .S00_AXI_0_awaddr(awaddr), .S00_AXI_0_awlen(awlen),
      .S00_AXI_0_awvalid(awvalid), .S00_AXI_0_awready(awready),
      .S00_AXI_0_awburst(2'b01), .S00_AXI_0_awsize(3'b100), .S00_AXI_0_awcache(4'd0),
      .S00_AXI_0_awlock(1'b0), .S00_AXI_0_awprot(3'd0), .S00_AXI_0_awqos(4'd0),
      .S00_AXI_0_wdata(wdata), .S00_AXI_0_wstrb(wstrb), .S00_AXI_0_wlast(wlast),
      .S00_AXI_0_wvalid(wvalid), .S00_AXI_0_wready(wready),
      .S00_AXI_0_bresp(bresp), .S00_AXI_0_bvalid(bvalid), .S00_AXI_0_bready(bready),
      .S00_AXI_0_araddr(araddr), .S00_AXI_0_arlen(arlen),
      .S00_AXI_0_arvalid(arvalid), .S00_AXI_0_arready(arready),
      .S00_AXI_0_arburst(2'b01), .S00_AXI_0_arsize(3'b100), .S00_AXI_0_arcache(4'd0),
      .S00_AXI_0_arlock(1'b0), .S00_AXI_0_arprot(3'd0), .S00_AXI_0_arqos(4'd0),
      .S00_AXI_0_rdata(rdata), .S00_AXI_0_rresp(rresp), .S00_AXI_0_rlast(rlast),
      .S00_AXI_0_rvalid(rvalid), .S00_AXI_0_rready(rready),
      .image_change(image_change), .irq_signal(irq_signal),
      .m_pix_tdata(tdata), .m_pix_tvalid(tvalid), .m_pix_tready(tready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [38:0] addr, input logic [127:0] data0,
                            input int unsigned beats, input logic [1:0] exp_resp);
      int unsigned n;
      bq.push_back(exp_resp);
      awaddr = addr; awlen = 8'(beats - 1); awvalid = 1'b1;
      n = 0;
      while (!awready && n < 100) begin tick(); n++; end
      if (!awready) check("awready_timeout", {127'd0, awready}, 128'd1);
      tick();
      awvalid = 1'b0;
      for (int unsigned k = 0; k < beats; k++) begin
         wdata = data0 + 128'(k); wstrb = '1; wlast = (k == beats - 1); wvalid = 1'b1;
         if (addr == A_PIX) pq.push_back(wdata);
         n = 0;
         while (!wready && n < 1000) begin tick(); n++; end
         if (!wready) check("wready_timeout", {127'd0, wready}, 128'd1);
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0;
      irq_at_last_beat = irq_signal;
      bready = 1'b1;
      n = 0;
      while (!bvalid && n < 100) begin tick(); n++; end
      check("bresp", {126'd0, bresp}, {126'd0, bq.pop_front()});
      tick();
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [38:0] addr, input logic [127:0] exp_data,
                           input logic [1:0] exp_resp);
      int unsigned n;
      rdq.push_back(exp_data); rrq.push_back(exp_resp);
      araddr = addr; arlen = 8'd0; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 100) begin tick(); n++; end
      if (!arready) check("arready_timeout", {127'd0, arready}, 128'd1);
      tick();
      arvalid = 1'b0;
      rready = 1'b1;
      n = 0;
      while (!rvalid && n < 100) begin tick(); n++; end
      check("rdata", rdata, rdq.pop_front());
      check("rresp_rlast", {125'd0, rresp, rlast}, {125'd0, rrq.pop_front(), 1'b1});
      tick();
      rready = 1'b0;
   endtask

   task automatic drain(input int unsigned beats);
      int unsigned n;
      tready = 1'b1;
      for (int unsigned k = 0; k < beats; k++) begin
         n = 0;
         while (!tvalid && n < 100) begin tick(); n++; end
         check("pix_data", tvalid ? tdata : 128'hX, (pq.size() > 0) ? pq.pop_front() : 128'h0);
         tick();
      end
      tready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
      wvalid = 1'b0; bready = 1'b0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
      image_change = 1'b0; tready = 1'b0;
      repeat (3) tick();
      check("rst_handshakes", {121'd0, awready, wready, bvalid, arready, rvalid, irq_signal, tvalid}, 128'd0);
      check("rst_rdata", rdata, 128'd0);
      rst = 1'b0;
      tick();

      // control register soft-reset pulse and readback
      axi_write(A_CTRL, 128'h2, 1, 2'b00);
      axi_write(A_CTRL, 128'h0, 1, 2'b00);
      axi_read(A_CTRL, 128'h0, 2'b00);
      check("irq_idle", {127'd0, irq_signal}, 128'd0);

      // geometry register
      axi_write(A_GEOM, 128'h780_0000_0438, 1, 2'b00);
      axi_read(A_GEOM, {64'd0, 32'h780, 32'h438}, 2'b00);

      // 1080p frame, auto-restart: first grant is BURST_MAX
      axi_write(A_FRAME, {32'd0, 32'd2073600, DRAM_BASE}, 1, 2'b00);
      axi_write(A_CTRL, 128'h9, 1, 2'b00);
      check("irq_first_request", {127'd0, irq_signal}, 128'd1);
      axi_read(A_FRAME, {64'd256, DRAM_BASE}, 2'b00);

      // full burst, ack, re-request, then stream it out in order
      axi_write(A_PIX, 128'h1000, 256, 2'b00);
      axi_write(A_ACK, 128'h1, 1, 2'b00);
      check("irq_ack_fall", {127'd0, irq_at_last_beat}, 128'd0);
      check("irq_rerise", {127'd0, irq_signal}, 128'd1);
      axi_read(A_FRAME, {64'd256, DRAM_BASE}, 2'b00);
      drain(256);

      // image_change mid-frame flushes the FIFO and re-requests
      axi_write(A_PIX, 128'hA0, 4, 2'b00);
      check("pix_valid_before_change", {127'd0, tvalid}, 128'd1);
      image_change = 1'b1;
      tick();
      image_change = 1'b0;
      check("change_flush_irq", {126'd0, tvalid, irq_signal}, 128'd0);
      tick();
      check("change_rerequest", {127'd0, irq_signal}, 128'd1);
      pq.delete();
      axi_read(A_FRAME, {64'd256, DRAM_BASE}, 2'b00);

      // short frame P=8 without auto-restart
      axi_write(A_CTRL, 128'h2, 1, 2'b00);
      axi_write(A_CTRL, 128'h0, 1, 2'b00);
      check("soft_reset_irq", {127'd0, irq_signal}, 128'd0);
      axi_write(A_FRAME, {32'd0, 32'd8, 64'd0}, 1, 2'b00);
      axi_write(A_CTRL, 128'h1, 1, 2'b00);
      check("short_irq", {127'd0, irq_signal}, 128'd1);
      axi_read(A_FRAME, {64'd2, 64'd0}, 2'b00);
      axi_write(A_PIX, 128'h5000, 2, 2'b00);
      axi_write(A_ACK, 128'h1, 1, 2'b00);
      check("short_ack_fall", {127'd0, irq_at_last_beat}, 128'd0);
      drain(2);
      repeat (10) tick();
      check("short_no_more_irq", {126'd0, irq_signal, tvalid}, 128'd0);
      axi_read(A_CTRL, 128'h0, 2'b00);

      // unmapped address
      axi_write(A_BAD, 128'hDEAD, 1, 2'b10);
      axi_read(A_BAD, 128'h0, 2'b10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/zcu104_main_blk_wrapper.md
Name: zcu104_main_blk_wrapper

Overview:
- Single-clock AXI4 slave (128-bit data, 39-bit address) combining a master control register and an image controller.
- Host writes frame geometry and length, then streams pixel data by AXI bursts into an internal FIFO.
- The FIFO drains to a pixel output stream.
- irq_signal requests the next burst; the host reads the granted burst length, writes the data, then acknowledges.

Parameters:
- FIFO_DEPTH, 512, pixel FIFO depth in 128-bit beats (power of 2).
- BURST_MAX, 256, maximum beats granted per IRQ request (≤256).
- CTRL_ADDR, 39'h00_A000_0000, master control register.
- IMG_BASE, 39'h00_A001_0000, image controller base; sub-offsets 0x00, 0x20, 0x30, 0x40.

Ports:
- s_axi_aclk  in  1  sole clock.
- s_axi_areset  in  1  asynchronous, active-high reset.
- S00_AXI_0_awaddr  in  39  write address.
- S00_AXI_0_awlen  in  8  write burst length minus 1.
- S00_AXI_0_awvalid/awready  in/out  1  write-address handshake.
- S00_AXI_0_wdata  in  128  write data.
- S00_AXI_0_wstrb  in  16  byte strobes.
- S00_AXI_0_wlast  in  1  last write beat.
- S00_AXI_0_wvalid/wready  in/out  1  write-data handshake.
- S00_AXI_0_bresp  out  2  write response.
- S00_AXI_0_bvalid/bready  out/in  1  write-response handshake.
- S00_AXI_0_araddr  in  39  read address.
- S00_AXI_0_arlen  in  8  read burst length minus 1.
- S00_AXI_0_arvalid/arready  in/out  1  read-address handshake.
- S00_AXI_0_rdata  out  128  read data.
- S00_AXI_0_rresp  out  2  read response.
- S00_AXI_0_rlast  out  1  last read beat.
- S00_AXI_0_rvalid/rready  out/in  1  read-data handshake.
- S00_AXI_0_{awburst,awsize,awcache,awlock,awprot,awqos,arburst,arsize,arcache,arlock,arprot,arqos}  in  AXI widths  ignored.
- image_change  in  1  new-image request (synchronous).
- irq_signal  out  1  level interrupt: burst request pending.
- m_pix_tdata  out  128  four 32-bit pixels, pixel 0 in [31:0].
- m_pix_tvalid/m_pix_tready  out/in  1  pixel stream handshake.

Behaviour:
- Reset values: all ready/valid outputs 0; irq_signal 0; rdata 0; registers 0; FIFO empty.
- Write FSM WI_IDLE→WI_DATA→WI_RESP:
  - In WI_IDLE, awready=1 for exactly one cycle on awvalid; latch address and awlen.
  - In WI_DATA, each beat with wvalid&wready is applied to the latched address (no address increment).
  - At offset 0x30, wready = FIFO not full. Other addresses take only the first beat; later beats are consumed and discarded.
  - Beat with wlast → WI_RESP. bvalid holds until bready, then WI_IDLE.
  - bresp=2'b00 for mapped addresses, 2'b10 otherwise.
- Read FSM RI_IDLE→RI_DATA:
  - arready=1 for one cycle.
  - arlen+1 beats of the same word; rlast on the final beat; rresp as bresp.
- CTRL (R/W, bits[3:0]):
  - bit0 start (begin frame).
  - bit1 soft reset: while 1, flush FIFO, clear irq, clear counters.
  - bit3 auto-restart at frame end.
- IMG_BASE+0x00:
  - Write: [63:0] DRAM base (stored only); [95:64] frame pixel count P. frame_beats = ceil(P/4).
  - Read: [63:0] base; [127:64] granted length L (1..BURST_MAX, 0 if none).
- IMG_BASE+0x20 (R/W): [31:0] height, [63:32] width; informational only.
- IMG_BASE+0x30: each beat pushes wdata into the FIFO. Read returns 0.
- IMG_BASE+0x40: write with bit0=1 clears irq_signal and re-arms the request logic.
- Request logic:
  - Conditions: running, no irq pending, requested < frame_beats, free slots ≥ min(BURST_MAX, frame_beats−requested).
  - Next cycle: L = that min; requested += L; irq_signal=1, held until ack.
- Output:
  - While running, m_pix_tvalid = FIFO non-empty; pop on valid&ready.
  - When popped == frame_beats: if auto, clear counters and continue; else clear start and stop.
- image_change=1 for one cycle: flush FIFO, clear irq and counters, restart frame if running.
- Precedence when events coincide: soft reset > image_change > ack > new request.
- Push on a full FIFO cannot occur because wready is gated.

Decomposition:
- Package zcu104_main_pkg: address constants, CTRL bit indices, write/read FSM enums, response codes.
- One sub-module zcu104_pix_fifo: synchronous FIFO with count output, flush input, async active-high reset.

Test Plan:
- Reset, then write 0x2 then 0x0 to CTRL → bresp 00 each; CTRL read returns 0x0; irq_signal 0.
- Write 0x780_0000_0438 to +0x20 → read returns height 0x438, width 0x780.
- Write +0x00 with P=1920*1080 and base 0x4_0000_0000, then CTRL=0x9 → irq_signal rises; read +0x00 gives [127:64]=256.
- Burst of 256 beats (awlen=0xFF, values i..i+255) to +0x30, then write 1 to +0x40 → irq falls and re-rises with L=256; m_pix_tdata emits i, i+1, … in order.
- P=8 (2 beats), auto off → L=2; after 2 pops the start bit clears, and no further irq occurs.
- Write to unmapped 0xA002_0000 → bresp 2'b10; reading it → rresp 2'b10; pulsing image_change mid-frame → FIFO empty, irq cleared then re-requested.
